// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - request, RAM port, writeback and exception signals of the MEM-stage LSU
interface lsu_mem_stage_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_store;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [4:0]    req_rd;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic [1:0]    mem_wtype;
   logic          mem_re;
   logic [AW-1:0] mem_raddr;
   logic [1:0]    mem_rtype;
   logic [31:0]   mem_rdata;

   logic          wb_valid;
   logic          wb_we;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;

   logic          exc_valid;
   logic [AW-1:0] exc_addr;

   // master: EX stage, RAM and writeback side; slave: the LSU itself
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
      input  req_ready, mem_we, mem_waddr, mem_wdata, mem_wtype, mem_re, mem_raddr, mem_rtype,
      input  wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_addr
   );
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
      output req_ready, mem_we, mem_waddr, mem_wdata, mem_wtype, mem_re, mem_raddr, mem_rtype,
      output wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_addr
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit driving the L1 data RAM ports
// Optional MISALIGN_TRAP_EN: misaligned H/W and invalid funct3 raise exc_valid instead of accessing RAM.
module lsu_mem_stage #(
   parameter int AW = 32
) (
   input  logic           clk,
   input  logic           rst,
   lsu_mem_stage_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          store_q;
   logic [2:0]    funct3_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [4:0]    rd_q;
   logic          accept;
   logic          fn_ok;
   logic          op_ok;

   assign accept = bus.req_valid && (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         rd_q     <= 5'd0;
      end else if (accept) begin
         store_q  <= bus.req_store;
         funct3_q <= bus.req_funct3;
         addr_q   <= bus.req_addr;
         wdata_q  <= bus.req_wdata;
         rd_q     <= bus.req_rd;
      end
   end

   // unsigned loads exist only for reads
   always_comb begin
      fn_ok = 1'b0;
      case (funct3_q)
         3'b000, 3'b001, 3'b010: fn_ok = 1'b1;
         3'b100, 3'b101:         fn_ok = !store_q;
         default:                fn_ok = 1'b0;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
   assign op_ok    = fn_ok && !misalign;
`else
   assign op_ok    = fn_ok;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = (!store_q && op_ok) ? RESP : IDLE;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.mem_we    = (state == ISSUE) && store_q && op_ok;
      bus.mem_re    = (state == ISSUE) && !store_q && op_ok;
      bus.mem_waddr = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_wtype = funct3_q[1:0];
      bus.mem_raddr = addr_q;
      bus.mem_rtype = funct3_q[1:0];
      bus.wb_valid  = (state == RESP);
      bus.wb_we     = (state == RESP) && (rd_q != 5'd0);
      bus.wb_rd     = (state == RESP) ? rd_q : 5'd0;
      bus.wb_data   = 32'h0;
      // RAM returns sign-extended data; only the unsigned forms need rework
      if (state == RESP) begin
         case (funct3_q)
            3'b100:  bus.wb_data = {24'h0, bus.mem_rdata[7:0]};
            3'b101:  bus.wb_data = {16'h0, bus.mem_rdata[15:0]};
            default: bus.wb_data = bus.mem_rdata;
         endcase
      end
`ifdef MISALIGN_TRAP_EN
      bus.exc_valid = (state == ISSUE) && !op_ok;
      bus.exc_addr  = ((state == ISSUE) && !op_ok) ? addr_q : '0;
`else
      bus.exc_valid = 1'b0;
      bus.exc_addr  = '0;
`endif
   end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed-vector bench for lsu_mem_stage with a byte-addressed RAM model
module tb_lsu_mem_stage;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;
   logic [7:0] ram [0:1023];

   always #5 clk = ~clk;

   lsu_mem_stage_if #(.AW(32)) bus ();
   lsu_mem_stage #(.AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   // RAM: write at the edge, registered sign-extended read
   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram[bus.mem_waddr[9:0]] <= bus.mem_wdata[7:0];
         if (bus.mem_wtype != 2'b00) ram[bus.mem_waddr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
         if (bus.mem_wtype == 2'b10) begin
            ram[bus.mem_waddr[9:0] + 10'd2] <= bus.mem_wdata[23:16];
            ram[bus.mem_waddr[9:0] + 10'd3] <= bus.mem_wdata[31:24];
         end
      end
      if (bus.mem_re) begin
         case (bus.mem_rtype)
            2'b00:   bus.mem_rdata <= {{24{ram[bus.mem_raddr[9:0]][7]}}, ram[bus.mem_raddr[9:0]]};
            2'b01:   bus.mem_rdata <= {{16{ram[bus.mem_raddr[9:0] + 10'd1][7]}},
                                       ram[bus.mem_raddr[9:0] + 10'd1], ram[bus.mem_raddr[9:0]]};
            default: bus.mem_rdata <= {ram[bus.mem_raddr[9:0] + 10'd3], ram[bus.mem_raddr[9:0] + 10'd2],
                                       ram[bus.mem_raddr[9:0] + 10'd1], ram[bus.mem_raddr[9:0]]};
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // entered and left on a negedge with the stage idle
   task automatic op(input string tag, input logic st, input logic [2:0] fn, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input logic exp_en,
                     input logic exp_wb, input logic [31:0] exp_data, input logic exp_exc);
      chk({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = fn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_rd     = rd;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk({tag, ".ready_issue"}, 32'(bus.req_ready), 32'd0);
      chk({tag, ".we"}, 32'(bus.mem_we), 32'(st & exp_en));
      chk({tag, ".re"}, 32'(bus.mem_re), 32'(!st & exp_en));
      chk({tag, ".exc"}, 32'(bus.exc_valid), 32'(exp_exc));
      chk({tag, ".exc_addr"}, bus.exc_addr, exp_exc ? addr : 32'h0);
      if (exp_en) begin
         chk({tag, ".addr"}, st ? bus.mem_waddr : bus.mem_raddr, addr);
         chk({tag, ".type"}, 32'(st ? bus.mem_wtype : bus.mem_rtype), 32'(fn[1:0]));
         if (st) chk({tag, ".wdata"}, bus.mem_wdata, wdata);
      end
      @(negedge clk);
      chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(exp_wb));
      chk({tag, ".we_after"}, 32'(bus.mem_we | bus.mem_re), 32'd0);
      if (exp_wb) begin
         chk({tag, ".wb_data"}, bus.wb_data, exp_data);
         chk({tag, ".wb_rd"}, 32'(bus.wb_rd), 32'(rd));
         chk({tag, ".wb_we"}, 32'(bus.wb_we), 32'(rd != 5'd0));
         @(negedge clk);
         chk({tag, ".wb_pulse"}, 32'(bus.wb_valid), 32'd0);
      end
   endtask

   logic [2:0]  b2b_fn   [3] = '{3'b010, 3'b100, 3'b001};
   logic [4:0]  b2b_rd   [3] = '{5'd1, 5'd2, 5'd4};
   logic [31:0] b2b_data [3] = '{32'hDEADBEEF, 32'h00000001, 32'hFFFF8001};
   logic [31:0] b2b_addr [3] = '{32'h100, 32'h104, 32'h104};

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      bus.mem_rdata  = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_rd     = 5'd0;

      @(negedge clk);
      chk("rst.ready", 32'(bus.req_ready), 32'd1);
      chk("rst.en", 32'({bus.mem_we, bus.mem_re, bus.wb_valid, bus.exc_valid}), 32'd0);
      chk("rst.waddr", bus.mem_waddr, 32'h0);
      chk("rst.wb_data", bus.wb_data, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      op("sw",  1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1, 0, 32'h0, 0);
      op("lw",  0, 3'b010, 32'h100, 32'h0, 5'd5, 1, 1, 32'hDEADBEEF, 0);
      op("sb",  1, 3'b000, 32'h104, 32'h12345680, 5'd0, 1, 0, 32'h0, 0);
      op("lb",  0, 3'b000, 32'h104, 32'h0, 5'd3, 1, 1, 32'hFFFFFF80, 0);
      op("lbu", 0, 3'b100, 32'h104, 32'h0, 5'd3, 1, 1, 32'h00000080, 0);
      op("sh",  1, 3'b001, 32'h104, 32'h00008001, 5'd0, 1, 0, 32'h0, 0);
      op("lhu", 0, 3'b101, 32'h104, 32'h0, 5'd7, 1, 1, 32'h00008001, 0);
      op("lh",  0, 3'b001, 32'h104, 32'h0, 5'd7, 1, 1, 32'hFFFF8001, 0);

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("b2b.ready%0d", i), 32'(bus.req_ready), 32'(i % 3 == 0));
         chk($sformatf("b2b.wbv%0d", i), 32'(bus.wb_valid), 32'(i % 3 == 2));
         if (i % 3 == 2) begin
            chk($sformatf("b2b.rd%0d", i), 32'(bus.wb_rd), 32'(b2b_rd[i / 3]));
            chk($sformatf("b2b.data%0d", i), bus.wb_data, b2b_data[i / 3]);
         end
         if (i % 3 == 0) begin
            bus.req_valid  = 1'b1;
            bus.req_store  = 1'b0;
            bus.req_funct3 = b2b_fn[i / 3];
            bus.req_addr   = b2b_addr[i / 3];
            bus.req_rd     = b2b_rd[i / 3];
         end
         if (i == 7) bus.req_valid = 1'b0;
         @(negedge clk);
      end

      op("lw_x0",  0, 3'b010, 32'h100, 32'h0, 5'd0, 1, 1, 32'hDEADBEEF, 0);
      op("ld011",  0, 3'b011, 32'h100, 32'h0, 5'd9, 0, 0, 32'h0, TRAP);
      op("sbu",    1, 3'b100, 32'h100, 32'hFF, 5'd0, 0, 0, 32'h0, TRAP);
      op("lw_chk", 0, 3'b010, 32'h100, 32'h0, 5'd2, 1, 1, 32'hDEADBEEF, 0);

      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h100;
      bus.req_rd     = 5'd9;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rstresp.wbv_before", 32'(bus.wb_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstresp.wbv", 32'(bus.wb_valid), 32'd0);
      chk("rstresp.wb_we", 32'(bus.wb_we), 32'd0);
      chk("rstresp.ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      op("lw_rel", 0, 3'b010, 32'h100, 32'h0, 5'd6, 1, 1, 32'hDEADBEEF, 0);

      op("sw104",  1, 3'b010, 32'h104, 32'h11223344, 5'd0, 1, 0, 32'h0, 0);
      op("lw_mis", 0, 3'b010, 32'h102, 32'h0, 5'd8, !TRAP, !TRAP, 32'h3344DEAD, TRAP);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
